// File: rtl/axon_scheduler_vote.sv
// axon_scheduler_vote: circular spike buffer with multi-port writes, sticky spiked vector and vote counters.
// Optional macro SCHED_DUP_DETECT_EN flags duplicate spike writes as errors.
module axon_scheduler_vote #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_TICKS   = 16,
  parameter int NUM_PORTS   = 2,
  parameter int VOTE_NUM    = 1,
  parameter int COUNT_WIDTH = 4,
  localparam int AW = $clog2(NUM_AXONS),
  localparam int TW = $clog2(NUM_TICKS),
  localparam int PW = AW + TW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    wen,
  input  logic [NUM_PORTS*PW-1:0] packet,
  input  logic                    set,
  input  logic                    clr,
  input  logic                    clr_avr,
  input  logic                    clr_spiked,
  output logic [NUM_AXONS-1:0]    axon_spikes,
  output logic [NUM_AXONS-1:0]    spiked,
  output logic [NUM_AXONS-1:0]    vote,
  output logic                    error
);
  logic [NUM_AXONS-1:0]   mem_q [NUM_TICKS];
  logic [NUM_AXONS-1:0]   mem_d [NUM_TICKS];
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_AXONS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_AXONS];
  logic [TW-1:0]          rptr_q, rptr_d, row;
  logic [AW-1:0]          ax;
  logic [NUM_AXONS-1:0]   spiked_q, spiked_d, cur;
  logic                   error_q, error_d;

  always_comb begin
    mem_d = mem_q;
    error_d = error_q;
    rptr_d = rptr_q + TW'(set);
    cur = mem_q[rptr_q];
    ax = '0;
    row = '0;
    if (clr) mem_d[rptr_q] = '0;
    // Writes are applied in port order so a later port sees earlier ports' bits when checking duplicates.
    for (int p = 0; p < NUM_PORTS; p++) begin
      ax = packet[p*PW +: AW];
      row = rptr_q + packet[p*PW+AW +: TW];
      if (wen[p]) begin
        if (int'(ax) >= NUM_AXONS) error_d = 1'b1;
        else if (clr && row == rptr_q) error_d = 1'b1;
        else begin
`ifdef SCHED_DUP_DETECT_EN
          if (mem_d[row][ax]) error_d = 1'b1;
`endif
          mem_d[row][ax] = 1'b1;
        end
      end
    end
    spiked_d = (clr_spiked ? '0 : spiked_q) | (clr ? cur : '0);
    for (int i = 0; i < NUM_AXONS; i++) begin
      cnt_d[i] = clr_avr ? '0 : cnt_q[i];
      if (clr && cur[i] && cnt_d[i] != '1) cnt_d[i] = cnt_d[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '{default: '0};
      rptr_q <= '0;
      spiked_q <= '0;
      error_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      rptr_q <= rptr_d;
      spiked_q <= spiked_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    vote = '0;
    for (int i = 0; i < NUM_AXONS; i++) vote[i] = cnt_q[i] >= COUNT_WIDTH'(VOTE_NUM);
  end

  assign axon_spikes = mem_q[rptr_q];
  assign spiked = spiked_q;
  assign error = error_q;
endmodule

// File: tb/tb_axon_scheduler_vote.sv
// tb_axon_scheduler_vote: directed vector table plus hand sequences for wrap, saturation, duplicate and collision.
module tb_axon_scheduler_vote;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   wen = '0;
  logic [23:0]  packet = '0;
  logic         set = 1'b0, clr = 1'b0, clr_avr = 1'b0, clr_spiked = 1'b0;
  logic [255:0] axon_spikes, spiked, vote;
  logic         error;
  int           n_chk = 0, n_fail = 0;

  axon_scheduler_vote #(.NUM_AXONS(256), .NUM_TICKS(16), .NUM_PORTS(2), .VOTE_NUM(2), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wen(wen), .packet(packet), .set(set), .clr(clr),
    .clr_avr(clr_avr), .clr_spiked(clr_spiked), .axon_spikes(axon_spikes),
    .spiked(spiked), .vote(vote), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [23:0] pkt;
    logic        set, clr, cavr, csp;
    int          idx;
    logic        ax;
    int          pop;
    logic        sp, vt;
  } vec_t;

  vec_t tv[18];

  function automatic logic [11:0] pk(input int off, input int a);
    return {4'(off), 8'(a)};
  endfunction

  function automatic vec_t mk(input int w, input int off, input int a, input int s, input int c,
                              input int ca, input int cs, input int idx, input int axe,
                              input int pop, input int sp, input int vt);
    vec_t v;
    v.wen = 2'(w);
    v.pkt = {12'd0, pk(off, a)};
    v.set = s[0];
    v.clr = c[0];
    v.cavr = ca[0];
    v.csp = cs[0];
    v.idx = idx;
    v.ax = axe[0];
    v.pop = pop;
    v.sp = sp[0];
    v.vt = vt[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] w, input logic [23:0] p, input logic s, input logic c,
                      input logic ca, input logic cs);
    wen = w;
    packet = p;
    set = s;
    clr = c;
    clr_avr = ca;
    clr_spiked = cs;
    @(posedge clk);
    #1;
    wen = '0;
    packet = '0;
    set = 1'b0;
    clr = 1'b0;
    clr_avr = 1'b0;
    clr_spiked = 1'b0;
  endtask

  initial begin
    tv[0]  = mk(1, 2, 5, 0, 0, 0, 0, 5, 0, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0);
    tv[3]  = mk(0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 1, 0);
    tv[4]  = mk(1, 1, 7, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 1, 0, 0, 0, 7, 1, 1, 0, 0);
    tv[6]  = mk(0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 0);
    tv[7]  = mk(1, 1, 7, 0, 0, 0, 0, 7, 0, 0, 1, 0);
    tv[8]  = mk(0, 0, 0, 1, 0, 0, 0, 7, 1, 1, 1, 0);
    tv[9]  = mk(0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1, 1);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1);
    tv[11] = mk(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0);
    tv[12] = mk(1, 1, 7, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    tv[13] = mk(0, 0, 0, 1, 0, 0, 0, 7, 1, 1, 0, 0);
    tv[14] = mk(0, 0, 0, 1, 1, 0, 0, 7, 0, 0, 1, 0);
    tv[15] = mk(1, 1, 7, 0, 0, 0, 0, 7, 0, 0, 1, 0);
    tv[16] = mk(0, 0, 0, 1, 0, 0, 0, 7, 1, 1, 1, 0);
    tv[17] = mk(0, 0, 0, 0, 1, 1, 1, 7, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_pop", $countones(axon_spikes), 0);
    chk("reset_spiked", $countones(spiked), 0);
    chk("reset_vote", $countones(vote), 0);
    chk("reset_error", int'(error), 0);

    for (int i = 0; i < 18; i++) begin
      step(tv[i].wen, tv[i].pkt, tv[i].set, tv[i].clr, tv[i].cavr, tv[i].csp);
      chk($sformatf("tv%0d_ax", i), int'(axon_spikes[tv[i].idx]), int'(tv[i].ax));
      chk($sformatf("tv%0d_pop", i), $countones(axon_spikes), tv[i].pop);
      chk($sformatf("tv%0d_spiked", i), int'(spiked[tv[i].idx]), int'(tv[i].sp));
      chk($sformatf("tv%0d_vote", i), int'(vote[tv[i].idx]), int'(tv[i].vt));
      chk($sformatf("tv%0d_error", i), int'(error), 0);
    end

    repeat (8) step(2'b00, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, {pk(1, 200), pk(1, 3)}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pre_pop", $countones(axon_spikes), 0);
    step(2'b00, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_bit3", int'(axon_spikes[3]), 1);
    chk("wrap_bit200", int'(axon_spikes[200]), 1);
    chk("wrap_pop", $countones(axon_spikes), 2);
    step(2'b00, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_cleared", $countones(axon_spikes), 0);

    for (int k = 0; k < 20; k++) begin
      step(2'b01, {12'd0, pk(1, 1)}, 1'b0, 1'b0, 1'b0, 1'b0);
      step(2'b00, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(2'b00, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("sat_cnt", int'(dut.cnt_q[1]), 15);
    chk("sat_vote", int'(vote[1]), 1);
    step(2'b00, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_clr_avr_vote", int'(vote[1]), 0);
    chk("sat_clr_avr_cnt", int'(dut.cnt_q[1]), 0);
    chk("pre_dup_error", int'(error), 0);

    step(2'b01, {12'd0, pk(3, 4)}, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b01, {12'd0, pk(3, 4)}, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SCHED_DUP_DETECT_EN
    chk("dup_error", int'(error), 1);
`else
    chk("dup_error", int'(error), 0);
`endif

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_error", int'(error), 0);
    chk("async_rst_vote", $countones(vote), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(2'b00, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_discard_bit4", int'(axon_spikes[4]), 0);

    step(2'b01, {12'd0, pk(0, 9)}, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("collision_error", int'(error), 1);
    for (int t = 0; t < 16; t++) begin
      chk($sformatf("collision_row%0d_bit9", t), int'(axon_spikes[9]), 0);
      step(2'b00, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("collision_error_sticky", int'(error), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axon_scheduler_vote.md
Name: axon_scheduler_vote

Overview:
- Multi-port, parametrised successor to the core's axon spike scheduler.
- Stores future axon spikes in a NUM_TICKS-deep circular buffer of NUM_AXONS-bit rows, and presents the current tick's row to the token controller.
- Accepts up to NUM_PORTS router packets per cycle.
- Accumulates consumed spikes into a sticky spiked vector and per-axon saturating vote counters for output-layer voting.

Parameters:
- NUM_AXONS, 256, axons per core; row width.
- NUM_TICKS, 16, buffer depth in ticks; power of two.
- NUM_PORTS, 2, parallel packet write ports.
- VOTE_NUM, 1, count at or above which an axon's vote bit asserts; 1..2^COUNT_WIDTH-1.
- COUNT_WIDTH, 4, per-axon vote counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset.
- wen  in  NUM_PORTS  per-port packet valid.
- packet  in  NUM_PORTS*(AW+TW)  port p at slice p*(AW+TW); each slice is {offset[TW-1:0], axon[AW-1:0]}, with AW=$clog2(NUM_AXONS) and TW=$clog2(NUM_TICKS).
- set  in  1  tick advance pulse.
- clr  in  1  consume and clear the current row.
- clr_avr  in  1  zero all vote counters.
- clr_spiked  in  1  zero the sticky spiked vector.
- axon_spikes  out  NUM_AXONS  current row, i.e. mem[rptr].
- spiked  out  NUM_AXONS  sticky OR of all consumed rows.
- vote  out  NUM_AXONS  vote[i] = (cnt[i] >= VOTE_NUM).
- error  out  1  sticky fault flag.

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - every mem row 0, rptr 0, all cnt 0, spiked 0, error 0.
  - hence axon_spikes=0 and vote=0.
- Write path:
  - each port with wen[p]=1 sets bit axon of row (rptr+offset) mod NUM_TICKS, where rptr is its pre-edge value.
  - writes land at the clock edge.
  - multiple ports hitting the same row and/or bit merge by OR.
  - axon values >= NUM_AXONS are only possible when NUM_AXONS is not a power of two; such a write is dropped and error is set.
- Tick advance:
  - set=1 updates rptr to rptr+1 mod NUM_TICKS (wraps from NUM_TICKS-1 to 0).
  - axon_spikes is combinational from registered mem/rptr, so the new row is visible the cycle after set.
  - a write in the same cycle as set uses the old rptr.
- Consume (clr=1), row r=rptr:
  - for every i with mem[r][i]=1: cnt[i] <= min(cnt[i]+1, 2^COUNT_WIDTH-1) and spiked[i] <= 1.
  - then mem[r] <= 0.
  - a write whose target row is r in the same cycle is lost (clr wins) and error is set.
  - writes to other rows are unaffected.
- set and clr in the same cycle: clr acts on the old row, set advances rptr. Total latency from clr to visible count/vote change is 1 cycle.
- Clear priority:
  - clr_avr together with clr: cnt[i] <= mem[r][i] (clear, then accumulate).
  - clr_spiked together with clr: spiked <= mem[r].
  - clr_avr/clr_spiked without clr: zero the respective state next edge.
- Counters saturate and never wrap. vote is a pure compare of registered counts.
- error:
  - sticky; cleared only by rst.
  - rst asserted mid-operation discards all pending spikes immediately (asynchronous).
- State: no FSM beyond rptr. Storage is flop-based (NUM_TICKS x NUM_AXONS) so that one-cycle row clear is possible.

Optional Feature:
- Macro: SCHED_DUP_DETECT_EN.
- Defined:
  - a write to a bit already 1 in mem sets error.
  - two ports writing the same row and axon in the same cycle also set error.
  - the stored value is unchanged (still 1).
- Undefined: duplicates merge silently; error is driven only by the clr collision and out-of-range axon conditions.

Test Plan:
- Basic delivery:
  - stimulus: rst, then port0 writes {offset=2, axon=5}, then set, set.
  - required: axon_spikes[5]=1 exactly after the 2nd set, 0 before.
- Dual-port merge and wrap:
  - stimulus: advance rptr to 15; same cycle port0 {1, 3}, port1 {1, 200}; then set.
  - required: rptr=0 and axon_spikes has bits 3 and 200 only.
- Consume and vote (VOTE_NUM=2):
  - stimulus: deliver axon 7 in two ticks, each followed by clr.
  - required: vote[7]=0 after the first clr, 1 after the second; spiked[7]=1 after the first clr; row reads 0 after each clr.
- Saturation:
  - stimulus: consume axon 1 twenty times (COUNT_WIDTH=4).
  - required: cnt stays 15, vote[1]=1; after clr_avr, vote[1]=0.
- Collision:
  - stimulus: clr with port0 {offset=0, axon=9} in the same cycle.
  - required: bit 9 is not set in any row; error=1 and stays 1 until rst.
- Duplicate (SCHED_DUP_DETECT_EN defined):
  - stimulus: write {3, 4} twice.
  - required: error=1; with the macro undefined, error=0.
